// File: rtl/avalon_mem_slave256.sv
// avalon_mem_slave256
// 256-bit Avalon-MM responder memory. It stands in for DRAM in simulation
// and serves as an on-chip scratch buffer in hardware. Each command is
// held off for a programmable number of waitrequest cycles, then taken in
// one cycle. Reads return over a fixed-latency pipeline in acceptance
// order, with a cap on outstanding reads. Out-of-range and read+write
// collision commands are counted for debug.
//
// Ports:
//   clk                  single clock
//   reset                synchronous, active-high reset
//   avs_s0_address       byte address; bits [4:0] ignored
//   avs_s0_read          read request
//   avs_s0_write         write request
//   avs_s0_writedata     full 256-bit write data
//   avs_s0_waitrequest   command not accepted this cycle
//   avs_s0_readdatavalid avs_s0_readdata valid this cycle
//   avs_s0_readdata      read data, holds its last value between returns
//   err_count            saturating count of bad commands
//   pending              accepted reads not yet returned
module avalon_mem_slave256 #(
    parameter int DEPTH        = 64,
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  avs_s0_address,
    input  logic         avs_s0_read,
    input  logic         avs_s0_write,
    input  logic [255:0] avs_s0_writedata,
    output logic         avs_s0_waitrequest,
    output logic         avs_s0_readdatavalid,
    output logic [255:0] avs_s0_readdata,
    output logic [15:0]  err_count,
    output logic [3:0]   pending
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 5;

    logic [255:0] mem [DEPTH];

    logic [CW-1:0] stall_cnt;
    logic [3:0]    pending_q;
    logic [15:0]   err_q;

    logic [READ_LATENCY-1:0] valid_q;
    logic [255:0]            data_q [READ_LATENCY];

    logic          cmd;
    logic          collide;
    logic          read_only;
    logic          out_of_range;
    logic [AW-1:0] word_idx;
    logic          stall_done;
    logic          read_blocked;
    logic          accept;
    logic          accept_read;
    logic          accept_write;
    logic          bad_cmd;
    logic          rdv;
    logic [255:0]  read_word;

    // Command decode. A collision is treated as a write: the read half is
    // dropped, so it neither waits for pipeline room nor returns data.
    // The stall counter walks 0..WAIT_CYCLES while a command is held; once
    // it reaches WAIT_CYCLES the command is taken, unless it is a read and
    // the pending limit is reached with no return freeing a slot this cycle.
    always_comb begin
        cmd          = avs_s0_read | avs_s0_write;
        collide      = avs_s0_read & avs_s0_write;
        read_only    = avs_s0_read & ~avs_s0_write;
        out_of_range = ({1'b0, avs_s0_address} >= ADDR_LIMIT);
        word_idx     = avs_s0_address[AW+4:5];
        rdv          = valid_q[READ_LATENCY-1];
        stall_done   = (stall_cnt >= CW'(WAIT_CYCLES));
        read_blocked = read_only & (pending_q >= 4'(MAX_PENDING)) & ~rdv;
        avs_s0_waitrequest = reset | (cmd & (~stall_done | read_blocked));
        accept       = cmd & ~avs_s0_waitrequest;
        accept_read  = accept & read_only;
        accept_write = accept & avs_s0_write;
        bad_cmd      = accept & (collide | out_of_range);
        read_word    = out_of_range ? '0 : mem[word_idx];
    end

    // Storage array. Not cleared by reset so contents survive it; an
    // out-of-range write must not alias onto a low word.
    always_ff @(posedge clk) begin
        if (accept_write && !out_of_range) begin
            mem[word_idx] <= avs_s0_writedata;
        end
    end

    // Stall counter, outstanding-read count and error counter. The counter
    // drops back to zero after each acceptance so every command pays the
    // full stall, and also when a command is withdrawn before acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            pending_q <= '0;
            err_q     <= '0;
        end else begin
            if (!cmd || accept) begin
                stall_cnt <= '0;
            end else if (!stall_done) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            if (accept_read && !rdv) begin
                pending_q <= pending_q + 4'd1;
            end else if (!accept_read && rdv) begin
                pending_q <= pending_q - 4'd1;
            end

            if (bad_cmd && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    // Read return pipeline. Each stage's data only moves when a valid token
    // moves into it, so the last stage (which drives readdata) keeps the
    // most recent returned word while readdatavalid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= accept_read;
            if (accept_read) begin
                data_q[0] <= read_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign avs_s0_readdatavalid = rdv;
    assign avs_s0_readdata      = data_q[READ_LATENCY-1];
    assign err_count            = err_q;
    assign pending              = pending_q;

endmodule

// File: tb/tb_avalon_mem_slave256.sv
// tb_avalon_mem_slave256
// Two instances: "a" uses WAIT_CYCLES=2, READ_LATENCY=2 and "b" uses
// WAIT_CYCLES=0, READ_LATENCY=8, both DEPTH=64 and MAX_PENDING=4.
// Expected data comes from plain word arrays updated on every accepted
// write; expected error counts are tallied per bad command issued.
module tb_avalon_mem_slave256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         reset_a, reset_b;
    logic [31:0]  a_addr, b_addr;
    logic         a_read, a_write, b_read, b_write;
    logic [255:0] a_wdata, b_wdata;
    logic         a_wr, b_wr, a_rdv, b_rdv;
    logic [255:0] a_rdata, b_rdata;
    logic [15:0]  a_err, b_err;
    logic [3:0]   a_pending, b_pending;

    avalon_mem_slave256 #(.DEPTH(64), .WAIT_CYCLES(2), .READ_LATENCY(2), .MAX_PENDING(4)) dut_a (
        .clk(clk), .reset(reset_a),
        .avs_s0_address(a_addr), .avs_s0_read(a_read), .avs_s0_write(a_write),
        .avs_s0_writedata(a_wdata), .avs_s0_waitrequest(a_wr),
        .avs_s0_readdatavalid(a_rdv), .avs_s0_readdata(a_rdata),
        .err_count(a_err), .pending(a_pending)
    );

    avalon_mem_slave256 #(.DEPTH(64), .WAIT_CYCLES(0), .READ_LATENCY(8), .MAX_PENDING(4)) dut_b (
        .clk(clk), .reset(reset_b),
        .avs_s0_address(b_addr), .avs_s0_read(b_read), .avs_s0_write(b_write),
        .avs_s0_writedata(b_wdata), .avs_s0_waitrequest(b_wr),
        .avs_s0_readdatavalid(b_rdv), .avs_s0_readdata(b_rdata),
        .err_count(b_err), .pending(b_pending)
    );

    int checks = 0;
    int errors = 0;

    logic [255:0] ref_a [64];
    logic [255:0] ref_b [64];
    int           exp_err_a = 0;

    int           qa_cyc[$], qb_cyc[$];
    logic [255:0] qa_dat[$], qb_dat[$];

    // Record every return with the cycle it was seen in.
    always @(negedge clk) begin
        if (a_rdv === 1'b1) begin
            qa_cyc.push_back(cyc);
            qa_dat.push_back(a_rdata);
        end
        if (b_rdv === 1'b1) begin
            qb_cyc.push_back(cyc);
            qb_dat.push_back(b_rdata);
        end
    end

    // Hard stop in case a step loses track of time.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic apply_stimulus(input int which, input logic rd, input logic wr,
                                  input logic [31:0] addr, input logic [255:0] data);
        if (which == 0) begin
            a_read = rd; a_write = wr; a_addr = addr; a_wdata = data;
        end else begin
            b_read = rd; b_write = wr; b_addr = addr; b_wdata = data;
        end
    endtask

    function automatic logic get_wr(input int which);
        return (which == 0) ? a_wr : b_wr;
    endfunction

    // Hold a command until it is taken; returns stall cycles and the
    // cycle in which it was accepted. Entered and left just after a posedge.
    task automatic do_cmd(input int which, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [255:0] data,
                          output int stalls, output int acc);
        apply_stimulus(which, rd, wr, addr, data);
        #1;
        stalls = 0;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            if (get_wr(which) === 1'b0) begin
                acc = cyc;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (acc >= 0) begin
            @(posedge clk); #1;
        end
        apply_stimulus(which, 1'b0, 1'b0, 32'h0, '0);
        check_output("accepted", (acc >= 0), 1);
    endtask

    task automatic write_word(input int which, input logic [31:0] addr, input logic [255:0] data, output int stalls);
        int acc;
        do_cmd(which, 1'b0, 1'b1, addr, data, stalls, acc);
        if (addr < 32'd2048) begin
            if (which == 0) ref_a[addr[10:5]] = data;
            else            ref_b[addr[10:5]] = data;
        end
    endtask

    task automatic read_word(input int which, input logic [31:0] addr, output int stalls, output int acc);
        do_cmd(which, 1'b1, 1'b0, addr, '0, stalls, acc);
    endtask

    task automatic expect_return(input int which, input int acc, input logic [255:0] exp, input string tag);
        int lat;
        int n;
        int rc;
        logic [255:0] rd;
        lat = (which == 0) ? 2 : 8;
        for (int i = 0; i < 30; i++) begin
            n = (which == 0) ? qa_cyc.size() : qb_cyc.size();
            if (n > 0) break;
            @(posedge clk); #1;
        end
        n = (which == 0) ? qa_cyc.size() : qb_cyc.size();
        check_output({tag, "_present"}, (n > 0), 1);
        if (n > 0) begin
            if (which == 0) begin
                rc = qa_cyc.pop_front(); rd = qa_dat.pop_front();
            end else begin
                rc = qb_cyc.pop_front(); rd = qb_dat.pop_front();
            end
            check_output({tag, "_latency"}, rc - acc, lat);
            check_output({tag, "_data"}, rd, exp);
        end
    endtask

    task automatic expect_none(input int which, input int ncyc, input string tag);
        repeat (ncyc) begin
            @(posedge clk); #1;
        end
        check_output(tag, (which == 0) ? qa_cyc.size() : qb_cyc.size(), 0);
    endtask

    initial begin
        int st, acc, k, peak, g;
        int accb[6];
        int wlist[$];
        logic [255:0] d, a5;

        a5 = {32{8'hA5}};
        apply_stimulus(0, 1'b0, 1'b0, 32'h0, '0);
        apply_stimulus(1, 1'b0, 1'b0, 32'h0, '0);
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_output("rst_waitreq_a", a_wr, 1);
        check_output("rst_waitreq_b", b_wr, 1);
        check_output("rst_rdv", a_rdv, 0);
        check_output("rst_readdata", a_rdata, 0);
        check_output("rst_err", a_err, 0);
        check_output("rst_pending", a_pending, 0);
        @(negedge clk);
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(posedge clk); #1;
        check_output("idle_waitreq", a_wr, 0);

        // Basic write then read with two stall cycles each.
        write_word(0, 32'h40, a5, st);
        check_output("wr_stalls", st, 2);
        read_word(0, 32'h40, st, acc);
        check_output("rd_stalls", st, 2);
        expect_return(0, acc, a5, "rd_a5");
        check_output("err_zero", a_err, 0);
        repeat (3) begin @(posedge clk); #1; end
        check_output("hold_rdv", a_rdv, 0);
        check_output("hold_data", a_rdata, a5);

        // Low address bits are ignored.
        d = rand256();
        write_word(0, 32'h20, d, st);
        read_word(0, 32'h3F, st, acc);
        expect_return(0, acc, d, "lowbits");

        // Random writes, each followed by a read of some written word.
        for (int i = 0; i < 6; i++) begin
            int w;
            w = $urandom_range(2, 63);
            write_word(0, 32'(w * 32 + $urandom_range(0, 31)), rand256(), st);
            wlist.push_back(w);
            w = wlist[$urandom_range(0, wlist.size() - 1)];
            read_word(0, 32'(w * 32 + $urandom_range(0, 31)), st, acc);
            expect_return(0, acc, ref_a[w], "rand_rd");
        end

        // Out-of-range read returns zero; out-of-range write leaves word 0.
        write_word(0, 32'h0, rand256(), st);
        read_word(0, 32'd2048, st, acc);
        exp_err_a++;
        expect_return(0, acc, '0, "oor_rd");
        check_output("oor_rd_err", a_err, exp_err_a);
        write_word(0, 32'd2048, rand256(), st);
        exp_err_a++;
        check_output("oor_wr_err", a_err, exp_err_a);
        read_word(0, 32'h0, st, acc);
        expect_return(0, acc, ref_a[0], "oor_wr_mem");

        // Read and write together: write wins, nothing returned.
        do_cmd(0, 1'b1, 1'b1, 32'h0, 256'h1, st, acc);
        ref_a[0] = 256'h1;
        exp_err_a++;
        check_output("coll_stalls", st, 2);
        expect_none(0, 6, "coll_no_rdv");
        check_output("coll_err", a_err, exp_err_a);
        read_word(0, 32'h0, st, acc);
        expect_return(0, acc, 256'h1, "coll_mem");

        // Command withdrawn while stalled: no effect, next one stalls fully.
        apply_stimulus(0, 1'b0, 1'b1, 32'h40, rand256());
        #1;
        check_output("wd_waitreq", a_wr, 1);
        @(posedge clk); #1;
        apply_stimulus(0, 1'b0, 1'b0, 32'h0, '0);
        @(posedge clk); #1;
        write_word(0, 32'h60, rand256(), st);
        check_output("wd_next_stalls", st, 2);
        read_word(0, 32'h40, st, acc);
        expect_return(0, acc, ref_a[2], "wd_mem");
        check_output("final_err_a", a_err, exp_err_a);
        check_output("final_pend_a", a_pending, 0);

        // Instance b: preload words 0..5, no stall expected.
        for (int i = 0; i < 6; i++) begin
            write_word(1, 32'(i * 32), rand256(), st);
            check_output("b_wr_stalls", st, 0);
        end

        // Hold read for six commands against a pending limit of four.
        k = 0;
        peak = 0;
        g = 0;
        b_read = 1'b1;
        b_addr = 32'h0;
        while (k < 6 && g < 60) begin
            #1;
            if (int'(b_pending) > peak) peak = int'(b_pending);
            if (b_wr === 1'b0) begin
                accb[k] = cyc;
                k++;
            end
            @(posedge clk); #1;
            if (k < 6) b_addr = 32'(k * 32);
            else       b_read = 1'b0;
            g++;
        end
        b_read = 1'b0;
        check_output("hold_count", k, 6);
        check_output("pend_peak", peak, 4);
        if (k == 6) begin
            for (int i = 1; i < 6; i++) begin
                check_output("hold_acc_cycle", accb[i] - accb[0], (i < 4) ? i : i + 4);
            end
            for (int i = 0; i < 6; i++) begin
                expect_return(1, accb[i], ref_b[i], "hold_ret");
            end
        end
        @(posedge clk); #1;
        check_output("pend_drained", b_pending, 0);

        // Reset with two reads in flight.
        read_word(1, 32'h0, st, acc);
        read_word(1, 32'h20, st, acc);
        check_output("pend_inflight", b_pending, 2);
        reset_b = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset_b = 1'b0;
        expect_none(1, 15, "rst_no_rdv");
        check_output("rst_pend_zero", b_pending, 0);
        read_word(1, 32'h40, st, acc);
        expect_return(1, acc, ref_b[2], "rst_mem_kept");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
